// File: rtl/blake2_msg_block_if.sv
// Byte-stream in / block-out bundle for the BLAKE2 message block assembler.
// The assembler takes the slave view; the producer/consumer side takes the master view.
interface blake2_msg_block_if #(
    parameter int W  = 32,
    parameter int NB = 16
) ();
    logic            byte_v_i;
    logic [7:0]      byte_i;
    logic            byte_last_i;
    logic            byte_ready_o;
    logic            empty_i;
    logic            blk_v_o;
    logic [NB*W-1:0] blk_o;
    logic            blk_last_o;
    logic [2*W-1:0]  blk_t_o;
    logic            blk_ready_i;

    modport slave (
        input  byte_v_i, byte_i, byte_last_i, empty_i, blk_ready_i,
        output byte_ready_o, blk_v_o, blk_o, blk_last_o, blk_t_o
    );

    modport master (
        output byte_v_i, byte_i, byte_last_i, empty_i, blk_ready_i,
        input  byte_ready_o, blk_v_o, blk_o, blk_last_o, blk_t_o
    );
endinterface

// File: rtl/blake2_msg_block.sv
// Packs a byte stream into zero-padded BLAKE2 message blocks and tracks the
// running byte counter t that the compression core needs for each block.
module blake2_msg_block #(
    parameter int W  = 32,
    parameter int NB = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    blake2_msg_block_if.slave msg_if
);
    localparam int BB = NB * W / 8;
    localparam int IW = $clog2(BB);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [2*W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] t_q, t_d;
    logic           last_q, last_d;

    logic accept;
    logic handoff;
    logic take_empty;
    logic close_blk;

    always_comb begin
        accept     = (state_q == FILL) && msg_if.byte_v_i;
        handoff    = (state_q == HOLD) && msg_if.blk_ready_i;
        // A zero-length message is only meaningful before any byte of a message arrived.
        take_empty = (state_q == FILL) && !msg_if.byte_v_i && msg_if.empty_i &&
                     (idx_q == '0) && (cnt_q == '0);
        close_blk  = accept && (msg_if.byte_last_i || (idx_q == IW'(BB - 1)));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        last_d  = last_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (close_blk) begin
                        state_d = HOLD;
                        t_d     = cnt_q + 1'b1;
                        last_d  = msg_if.byte_last_i;
                    end
                end else if (take_empty) begin
                    state_d = HOLD;
                    t_d     = '0;
                    last_d  = 1'b1;
                end
            end
            HOLD: begin
                if (msg_if.blk_ready_i) begin
                    state_d = FILL;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    // Only the final block ends the message; intermediate blocks keep counting.
                    if (last_q) begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            last_q  <= last_d;
        end
    end

    // One byte lane per block byte; unwritten lanes stay zero, which is the padding.
    for (genvar gi = 0; gi < BB; gi++) begin : g_lane
        logic [7:0] lane_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else if (handoff) begin
                lane_q <= '0;
            end else if (accept && (idx_q == IW'(gi))) begin
                lane_q <= msg_if.byte_i;
            end
        end

        assign msg_if.blk_o[8*gi +: 8] = lane_q;
    end

    assign msg_if.byte_ready_o = (state_q == FILL);
    assign msg_if.blk_v_o      = (state_q == HOLD);
    assign msg_if.blk_last_o   = last_q;
    assign msg_if.blk_t_o      = t_q;
endmodule

// File: tb/tb_blake2_msg_block.sv
// Directed bench for blake2_msg_block: a BLAKE2s instance and a BLAKE2b instance
// share clock and reset; each scenario task checks its own expected values.
module tb_blake2_msg_block;
    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    blake2_msg_block_if #(.W(32), .NB(16)) bus32 ();
    blake2_msg_block_if #(.W(64), .NB(16)) bus64 ();

    blake2_msg_block #(.W(32), .NB(16)) dut32 (.clk(clk), .rst_n(rst_n), .msg_if(bus32));
    blake2_msg_block #(.W(64), .NB(16)) dut64 (.clk(clk), .rst_n(rst_n), .msg_if(bus64));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [7:0] b, input logic l);
        bus32.byte_v_i    = 1'b1;
        bus32.byte_i      = b;
        bus32.byte_last_i = l;
        tick();
        bus32.byte_v_i    = 1'b0;
        bus32.byte_last_i = 1'b0;
    endtask

    task automatic send64(input logic [7:0] b, input logic l);
        bus64.byte_v_i    = 1'b1;
        bus64.byte_i      = b;
        bus64.byte_last_i = l;
        tick();
        bus64.byte_v_i    = 1'b0;
        bus64.byte_last_i = 1'b0;
    endtask

    task automatic hs32();
        bus32.blk_ready_i = 1'b1;
        tick();
        bus32.blk_ready_i = 1'b0;
    endtask

    task automatic hs64();
        bus64.blk_ready_i = 1'b1;
        tick();
        bus64.blk_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bus32.byte_v_i = 0; bus32.byte_i = 0; bus32.byte_last_i = 0;
        bus32.empty_i  = 0; bus32.blk_ready_i = 0;
        bus64.byte_v_i = 0; bus64.byte_i = 0; bus64.byte_last_i = 0;
        bus64.empty_i  = 0; bus64.blk_ready_i = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus32.blk_v_o !== 1'b0 || bus32.blk_t_o !== 64'd0 || bus32.blk_last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold32 v=%0b t=%0d last=%0b required v=0 t=0 last=0",
                     bus32.blk_v_o, bus32.blk_t_o, bus32.blk_last_o);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus32.byte_ready_o !== 1'b1 || bus32.blk_v_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_rel32 ready=%0b v=%0b required ready=1 v=0",
                     bus32.byte_ready_o, bus32.blk_v_o);
        end
        checks++;
        if (bus32.blk_o !== 512'd0 || bus32.blk_t_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_data32 blk=%h t=%0d required 0", bus32.blk_o, bus32.blk_t_o);
        end
        checks++;
        if (bus64.byte_ready_o !== 1'b1 || bus64.blk_v_o !== 1'b0 ||
            bus64.blk_o !== 1024'd0 || bus64.blk_t_o !== 128'd0) begin
            failures++;
            $display("FAIL reset_rel64 ready=%0b v=%0b t=%0d required ready=1 v=0 t=0",
                     bus64.byte_ready_o, bus64.blk_v_o, bus64.blk_t_o);
        end
    endtask

    task automatic test_abc();
        send32(8'h61, 1'b0);
        send32(8'h62, 1'b0);
        checks++;
        if (bus32.blk_v_o !== 1'b0 || bus32.byte_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL abc_midfill v=%0b ready=%0b required v=0 ready=1",
                     bus32.blk_v_o, bus32.byte_ready_o);
        end
        send32(8'h63, 1'b1);
        checks++;
        if (bus32.blk_v_o !== 1'b1 || bus32.byte_ready_o !== 1'b0 || bus32.blk_last_o !== 1'b1) begin
            failures++;
            $display("FAIL abc_hold v=%0b ready=%0b last=%0b required v=1 ready=0 last=1",
                     bus32.blk_v_o, bus32.byte_ready_o, bus32.blk_last_o);
        end
        checks++;
        if (bus32.blk_o !== 512'h636261 || bus32.blk_t_o !== 64'd3) begin
            failures++;
            $display("FAIL abc_data blk=%h t=%0d required blk=636261 t=3", bus32.blk_o, bus32.blk_t_o);
        end
        hs32();
        checks++;
        if (bus32.blk_v_o !== 1'b0 || bus32.byte_ready_o !== 1'b1 || bus32.blk_o !== 512'd0) begin
            failures++;
            $display("FAIL abc_handoff v=%0b ready=%0b blk=%h required v=0 ready=1 blk=0",
                     bus32.blk_v_o, bus32.byte_ready_o, bus32.blk_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp_blk;
        for (int k = 0; k < 64; k++) exp_blk[8*k +: 8] = 8'(k);
        for (int k = 0; k < 64; k++) send32(8'(k), 1'b0);
        checks++;
        if (bus32.blk_v_o !== 1'b1 || bus32.blk_last_o !== 1'b0 || bus32.blk_t_o !== 64'd64) begin
            failures++;
            $display("FAIL full_blk1 v=%0b last=%0b t=%0d required v=1 last=0 t=64",
                     bus32.blk_v_o, bus32.blk_last_o, bus32.blk_t_o);
        end
        checks++;
        if (bus32.blk_o !== exp_blk) begin
            failures++;
            $display("FAIL full_blk1_data blk=%h required %h", bus32.blk_o, exp_blk);
        end
        // Backpressure: offered bytes must be refused while the block is held.
        for (int c = 0; c < 5; c++) begin
            bus32.byte_v_i = 1'b1;
            bus32.byte_i   = 8'hEE;
            tick();
            checks++;
            if (bus32.blk_o !== exp_blk || bus32.blk_t_o !== 64'd64 ||
                bus32.byte_ready_o !== 1'b0 || bus32.blk_v_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_%0d t=%0d ready=%0b v=%0b required t=64 ready=0 v=1 blk unchanged",
                         c, bus32.blk_t_o, bus32.byte_ready_o, bus32.blk_v_o);
            end
        end
        bus32.byte_v_i = 1'b0;
        hs32();
        checks++;
        if (bus32.byte_ready_o !== 1'b1 || bus32.blk_v_o !== 1'b0 || bus32.blk_o !== 512'd0) begin
            failures++;
            $display("FAIL stall_resume ready=%0b v=%0b blk=%h required ready=1 v=0 blk=0",
                     bus32.byte_ready_o, bus32.blk_v_o, bus32.blk_o);
        end
        send32(8'hAA, 1'b1);
        checks++;
        if (bus32.blk_v_o !== 1'b1 || bus32.blk_o !== 512'hAA ||
            bus32.blk_t_o !== 64'd65 || bus32.blk_last_o !== 1'b1) begin
            failures++;
            $display("FAIL full_blk2 v=%0b blk=%h t=%0d last=%0b required v=1 blk=aa t=65 last=1",
                     bus32.blk_v_o, bus32.blk_o, bus32.blk_t_o, bus32.blk_last_o);
        end
        hs32();
    endtask

    task automatic test_exact_then_empty();
        for (int k = 0; k < 64; k++) send32(8'hC3, (k == 63) ? 1'b1 : 1'b0);
        checks++;
        if (bus32.blk_v_o !== 1'b1 || bus32.blk_t_o !== 64'd64 || bus32.blk_last_o !== 1'b1) begin
            failures++;
            $display("FAIL exact_blk v=%0b t=%0d last=%0b required v=1 t=64 last=1",
                     bus32.blk_v_o, bus32.blk_t_o, bus32.blk_last_o);
        end
        hs32();
        bus32.empty_i = 1'b1;
        tick();
        bus32.empty_i = 1'b0;
        checks++;
        if (bus32.blk_v_o !== 1'b1 || bus32.blk_o !== 512'd0 ||
            bus32.blk_t_o !== 64'd0 || bus32.blk_last_o !== 1'b1) begin
            failures++;
            $display("FAIL empty_blk v=%0b blk=%h t=%0d last=%0b required v=1 blk=0 t=0 last=1",
                     bus32.blk_v_o, bus32.blk_o, bus32.blk_t_o, bus32.blk_last_o);
        end
        hs32();
    endtask

    task automatic test_empty_priority();
        // Byte wins over a simultaneous empty request; later empty mid-message is ignored.
        bus32.empty_i = 1'b1;
        send32(8'h5A, 1'b0);
        checks++;
        if (bus32.blk_v_o !== 1'b0 || bus32.byte_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL empty_prio v=%0b ready=%0b required v=0 ready=1",
                     bus32.blk_v_o, bus32.byte_ready_o);
        end
        tick();
        bus32.empty_i = 1'b0;
        checks++;
        if (bus32.blk_v_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_ignored v=%0b required 0", bus32.blk_v_o);
        end
        send32(8'h5B, 1'b1);
        checks++;
        if (bus32.blk_v_o !== 1'b1 || bus32.blk_o !== 512'h5B5A ||
            bus32.blk_t_o !== 64'd2 || bus32.blk_last_o !== 1'b1) begin
            failures++;
            $display("FAIL empty_prio_blk v=%0b blk=%h t=%0d last=%0b required v=1 blk=5b5a t=2 last=1",
                     bus32.blk_v_o, bus32.blk_o, bus32.blk_t_o, bus32.blk_last_o);
        end
        hs32();
    endtask

    task automatic test_reset_mid_b64();
        logic [1023:0] exp_blk;
        for (int k = 0; k < 10; k++) send64(8'h10 + 8'(k), 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus64.blk_o !== 1024'd0 || bus64.blk_v_o !== 1'b0 || bus64.byte_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_async64 blk=%h v=%0b ready=%0b required blk=0 v=0 ready=1",
                     bus64.blk_o, bus64.blk_v_o, bus64.byte_ready_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 128; k++) exp_blk[8*k +: 8] = 8'(k);
        for (int k = 0; k < 128; k++) send64(8'(k), 1'b0);
        checks++;
        if (bus64.blk_v_o !== 1'b1 || bus64.blk_t_o !== 128'd128 || bus64.blk_last_o !== 1'b0) begin
            failures++;
            $display("FAIL b64_blk1 v=%0b t=%0d last=%0b required v=1 t=128 last=0",
                     bus64.blk_v_o, bus64.blk_t_o, bus64.blk_last_o);
        end
        checks++;
        if (bus64.blk_o !== exp_blk) begin
            failures++;
            $display("FAIL b64_blk1_data blk=%h required %h", bus64.blk_o, exp_blk);
        end
        hs64();
        send64(8'h80, 1'b0);
        send64(8'h81, 1'b1);
        checks++;
        if (bus64.blk_v_o !== 1'b1 || bus64.blk_o !== 1024'h8180 ||
            bus64.blk_t_o !== 128'd130 || bus64.blk_last_o !== 1'b1) begin
            failures++;
            $display("FAIL b64_blk2 v=%0b blk=%h t=%0d last=%0b required v=1 blk=8180 t=130 last=1",
                     bus64.blk_v_o, bus64.blk_o, bus64.blk_t_o, bus64.blk_last_o);
        end
        hs64();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_back_to_back();
        test_exact_then_empty();
        test_empty_priority();
        test_reset_mid_b64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/blake2_msg_block.md
BLAKE2_MSG_BLOCK -- requirements
Module: blake2_msg_block

Interface
REQ-001 SHALL have parameter: W, 32, hash word width in bits; legal values 32 (BLAKE2s) and 64 (BLAKE2b).
REQ-002 SHALL have parameter: NB, 16, words per message block; block size BB = NB*W/8 bytes.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: byte_v_i  input  1  input byte valid.
REQ-006 SHALL have port: byte_i  input  8  message byte.
REQ-007 SHALL have port: byte_last_i  input  1  qualifies byte_i as final byte of the message.
REQ-008 SHALL have port: byte_ready_o  output  1  byte accepted when byte_v_i & byte_ready_o.
REQ-009 SHALL have port: empty_i  input  1  single-cycle request to emit a zero-length message.
REQ-010 SHALL have port: blk_v_o  output  1  assembled block valid.
REQ-011 SHALL have port: blk_o  output  NB*W  assembled block, zero-padded.
REQ-012 SHALL have port: blk_last_o  output  1  block is final block of message.
REQ-013 SHALL have port: blk_t_o  output  2*W  cumulative message byte count including this block.
REQ-014 SHALL have port: blk_ready_i  input  1  core consumes block when blk_v_o & blk_ready_i.

Function
REQ-015 SHALL implement two states: FILL (byte_ready_o=1, blk_v_o=0) and HOLD (byte_ready_o=0, blk_v_o=1).
REQ-016 SHALL, in FILL, write the k-th accepted byte of the block (k=0..BB-1) to blk_o[8k+7:8k] (little-endian word packing), one byte per cycle max.
REQ-017 SHALL increment an in-block index and the 2W-bit message counter on each accepted byte; counter wraps modulo 2^(2W).
REQ-018 SHALL transition FILL->HOLD on the cycle after accepting byte index BB-1 or any byte with byte_last_i=1; blk_v_o rises 1 cycle after that byte.
REQ-019 SHALL set blk_last_o=1 in HOLD iff the block was closed by byte_last_i or empty_i; a full block closed without byte_last_i has blk_last_o=0.
REQ-020 SHALL keep bytes beyond the last written index at zero (padding); buffer is cleared on each handoff.
REQ-021 SHALL hold blk_o, blk_last_o, blk_t_o stable while blk_v_o=1 and blk_ready_i=0; byte_v_i ignored in HOLD.
REQ-022 SHALL, on blk_v_o & blk_ready_i, clear buffer and in-block index, return to FILL next cycle (no same-cycle bypass); message counter cleared only if blk_last_o=1.
REQ-023 SHALL accept empty_i only in FILL with in-block index 0, message counter 0 and byte_v_i=0; then enter HOLD next cycle with blk_o all zero, blk_t_o=0, blk_last_o=1. Otherwise empty_i is ignored.
REQ-024 SHALL give byte_v_i priority over empty_i when both are high in the same cycle.
REQ-025 SHALL drive blk_t_o from the message counter value latched at FILL->HOLD.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state FILL, blk_v_o=0, blk_last_o=0, blk_o=0, blk_t_o=0, in-block index 0, message counter 0.
REQ-027 SHALL drive byte_ready_o=1 on the first clock edge after rst_n deasserts; reset mid-message discards all buffered bytes and pending block.

Verification
REQ-028 SHALL cover: reset release -> byte_ready_o=1, blk_v_o=0, blk_o=0, blk_t_o=0.
REQ-029 SHALL cover (W=32): bytes 0x61,0x62,0x63 with last on 0x63 -> one cycle later blk_v_o=1, blk_o[23:0]=0x636261, rest 0, blk_t_o=3, blk_last_o=1.
REQ-030 SHALL cover (W=32): 64 bytes no last, then 1 byte 0xAA last -> block1 blk_t_o=64 last=0; block2 blk_o[7:0]=0xAA, rest 0, blk_t_o=65, last=1.
REQ-031 SHALL cover: 64 bytes with last on byte 64 -> single block, blk_t_o=64, blk_last_o=1; then empty_i -> zero block, blk_t_o=0, last=1.
REQ-032 SHALL cover: blk_ready_i low 5 cycles with byte_v_i=1 -> blk_o/blk_t_o unchanged, byte_ready_o=0, no byte consumed; FILL resumes cycle after handshake.
REQ-033 SHALL cover (W=64, NB=16): rst_n pulsed low after 10 bytes -> outputs cleared immediately; next 130-byte message yields blocks with blk_t_o=128 (last=0) then 130 (last=1).
